// File: rtl/ffra_sched.sv
// ffra_sched -- round-robin scheduler sharing one ffra multiply-add datapath
// (o = a*b + ci) among N requesters.
//
// Each requester offers operands with a valid/ready handshake. The granted
// operands are registered onto the ffra inputs. A {valid, id} shift register
// of depth LAT+1 follows each issue through the datapath latency, and the
// result is returned with the id of the requester that owns it.
//
// Build option:
//   FFRA_SCHED_PRIO_EN  when defined, requester 0 has strict priority over
//                       the round-robin group 1..N-1 and does not move ptr.
//
// Parameters:
//   N    number of requesters (2..8)
//   LAT  cycles from ffra input change to valid ffra_o (0..4)
//   IDW  width of rsp_id, 2**IDW >= N
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   pause            blocks new grants; in-flight work still completes
//   req_valid[N]     request present per requester
//   req_ready[N]     one-hot grant (combinational)
//   req_a/req_b      8-bit operands, requester i at [8i+7:8i]
//   req_c            16-bit addend, requester i at [16i+15:16i]
//   ffra_a/b/ci      registered operands to the datapath
//   ffra_o           datapath result
//   rsp_valid        one-cycle result strobe
//   rsp_id           owner of the result
//   rsp_data         registered result
//   busy             any operation in flight or being returned
module ffra_sched #(
    parameter int N   = 4,
    parameter int LAT = 1,
    parameter int IDW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pause,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [8*N-1:0]    req_a,
    input  logic [8*N-1:0]    req_b,
    input  logic [16*N-1:0]   req_c,
    output logic [7:0]        ffra_a,
    output logic [7:0]        ffra_b,
    output logic [15:0]       ffra_ci,
    input  logic [15:0]       ffra_o,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_data,
    output logic              busy
);

`ifdef FFRA_SCHED_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    localparam logic [N-1:0]   REQ_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0] ID_ONE  = {{(IDW-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0] ID_LAST = IDW'(N - 1);

    genvar gi;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [IDW-1:0] ptr_reg;
    logic [N-1:0]   above_ptr;
    logic [N-1:0]   masked_valid;
    logic [N-1:0]   lowest_masked;
    logic [N-1:0]   lowest_all;
    logic [N-1:0]   grant_vec;
    logic [IDW-1:0] grant_idx;
    logic [7:0]     sel_a;
    logic [7:0]     sel_b;
    logic [15:0]    sel_c;
    logic           xfer;

    // Bits at or above the pointer form the first search window.
    generate
        for (gi = 0; gi < N; gi++) begin : g_window
            assign above_ptr[gi] = (IDW'(gi) >= ptr_reg);
        end
    endgenerate

    // x & -x isolates the lowest set bit. Searching the window first and
    // falling back to the whole vector gives ptr, ptr+1, ... mod N order.
    assign masked_valid  = req_valid & above_ptr;
    assign lowest_masked = masked_valid & (~masked_valid + REQ_ONE);
    assign lowest_all    = req_valid & (~req_valid + REQ_ONE);

    always_comb begin
        grant_vec = '0;
        if (!rst && !pause) begin
            if (PRIO_EN && req_valid[0]) begin
                grant_vec = REQ_ONE;
            end else if (|masked_valid) begin
                grant_vec = lowest_masked;
            end else begin
                grant_vec = lowest_all;
            end
        end
    end

    assign req_ready = grant_vec;
    assign xfer      = |grant_vec;

    // grant_vec is one-hot, so at most one iteration assigns.
    always_comb begin
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_c     = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_vec[i]) begin
                grant_idx = IDW'(i);
                sel_a     = req_a[8*i +: 8];
                sel_b     = req_b[8*i +: 8];
                sel_c     = req_c[16*i +: 16];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointer and operand registers
    // ------------------------------------------------------------------
    logic [7:0]  ffra_a_reg;
    logic [7:0]  ffra_b_reg;
    logic [15:0] ffra_ci_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg     <= '0;
            ffra_a_reg  <= '0;
            ffra_b_reg  <= '0;
            ffra_ci_reg <= '0;
        end else if (xfer) begin
            ffra_a_reg  <= sel_a;
            ffra_b_reg  <= sel_b;
            ffra_ci_reg <= sel_c;
            // A priority grant to requester 0 leaves the rotation untouched.
            if (!(PRIO_EN && grant_idx == '0)) begin
                ptr_reg <= (grant_idx == ID_LAST) ? '0 : grant_idx + ID_ONE;
            end
        end
    end

    assign ffra_a  = ffra_a_reg;
    assign ffra_b  = ffra_b_reg;
    assign ffra_ci = ffra_ci_reg;

    // ------------------------------------------------------------------
    // Tracking: stage 0 is loaded with the issue, the tail (stage LAT)
    // lines up with the cycle in which ffra_o holds that issue's result.
    // ------------------------------------------------------------------
    logic           trk_v_reg  [0:LAT];
    logic [IDW-1:0] trk_id_reg [0:LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= LAT; k++) begin
                trk_v_reg[k]  <= 1'b0;
                trk_id_reg[k] <= '0;
            end
        end else begin
            trk_v_reg[0]  <= xfer;
            trk_id_reg[0] <= grant_idx;
            for (int k = 1; k <= LAT; k++) begin
                trk_v_reg[k]  <= trk_v_reg[k-1];
                trk_id_reg[k] <= trk_id_reg[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response
    // ------------------------------------------------------------------
    logic           rsp_valid_reg;
    logic [IDW-1:0] rsp_id_reg;
    logic [15:0]    rsp_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_data_reg  <= '0;
        end else begin
            rsp_valid_reg <= trk_v_reg[LAT];
            if (trk_v_reg[LAT]) begin
                rsp_id_reg   <= trk_id_reg[LAT];
                rsp_data_reg <= ffra_o;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;

    logic busy_next;

    always_comb begin
        busy_next = rsp_valid_reg;
        for (int k = 0; k <= LAT; k++) begin
            busy_next = busy_next | trk_v_reg[k];
        end
    end

    assign busy = busy_next;

endmodule

// File: doc/ffra_sched.md
# ffra_sched

Round-robin scheduler that shares one `ffra` multiply-add datapath (o = a*b + ci) among N requesters. Each requester presents operands with a valid/ready handshake. The scheduler registers the granted operands onto the `ffra` inputs and tracks each in-flight operation through the datapath's fixed latency. It returns every result with the originating requester ID. It sits between the user-project wrapper's request sources and a single `ffra` instance.

## Interface
Parameters:
- `N`, default 4: number of requesters, 2..8.
- `LAT`, default 1: cycles from `ffra` input change to valid `ffra_o`, 0..4.
- `IDW`, default 3: width of `rsp_id`; must satisfy 2^IDW >= N.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `pause`  in  1: when 1, no new grants; in-flight operations complete.
- `req_valid`  in  N: request present, one bit per requester.
- `req_ready`  out  N: grant; at most one bit is high per cycle.
- `req_a`  in  8*N: operand a; requester i uses bits [8i+7:8i].
- `req_b`  in  8*N: operand b, packed the same way as `req_a`.
- `req_c`  in  16*N: addend ci; requester i uses bits [16i+15:16i].
- `ffra_a`  out  8: registered operand a to `ffra`.
- `ffra_b`  out  8: registered operand b to `ffra`.
- `ffra_ci`  out  16: registered addend to `ffra`.
- `ffra_o`  in  16: `ffra` result.
- `rsp_valid`  out  1: one-cycle result strobe.
- `rsp_id`  out  IDW: index of the requester that owns the result.
- `rsp_data`  out  16: registered result.
- `busy`  out  1: 1 while any operation is in flight.

## Operation
- Handshake: a transfer occurs on a rising edge where `req_valid[i] & req_ready[i]` is 1.
  - `req_ready` is combinational from `req_valid`, the round-robin pointer and `pause`.
  - Once a requester raises `req_valid`, it holds the signal and its operands stable until the transfer.
- Arbitration: the round-robin pointer `ptr` (reset value 0) names the highest-priority requester.
  - The grant goes to the first requester with valid set, searching `ptr`, `ptr`+1, … modulo N.
  - After a transfer to requester g, `ptr` becomes (g+1) mod N. With no transfer, `ptr` holds.
- Issue: on a transfer, `ffra_a`, `ffra_b` and `ffra_ci` load the granted operands. With no transfer they hold their previous values.
- Tracking: a shift register of depth LAT+1 carries {valid, id} per issue slot.
- Result: when the tracking tail is valid, the scheduler registers `rsp_data` ← `ffra_o`, `rsp_id` ← id and `rsp_valid` ← 1.
- Responses have no backpressure. Issue rate is at most one per cycle, sustained.
- Arithmetic is unsigned: result = (a*b + ci) mod 2^16, with a*b zero-extended to 16 bits.
- `busy` = OR of all tracking valid bits, plus `rsp_valid`.
- `pause` does not affect the tracking shift register.
- Simultaneous events:
  - A new grant and a `rsp_valid` for an earlier request in the same cycle are independent of each other.
  - Requester i may be regranted while its own result is still in flight.

## Timing
- Reset (asynchronous): the following all go to 0 immediately:
  - `ptr`, all tracking bits;
  - `ffra_a`, `ffra_b`, `ffra_ci`;
  - `rsp_valid`, `rsp_id`, `rsp_data`, `busy`.
- While `rst` is high, `req_ready` = 0.
- Reset mid-operation drops in-flight results. No response is produced for them after reset releases.
- Latency: with the transfer on edge t, `ffra_*` are valid after edge t. `rsp_valid` is high for exactly the cycle following edge t+LAT+1.
- Back-to-back transfers on consecutive edges give `rsp_valid` on consecutive cycles, in issue order.
- `pause` rising in a cycle forces `req_ready` = 0 in that same cycle.

## Configuration
- `FFRA_SCHED_PRIO_EN`:
  - Defined: requester 0 has strict priority. Whenever `req_valid[0]` = 1 and `pause` = 0, requester 0 is granted regardless of `ptr`, and `ptr` is not updated. Requesters 1..N-1 arbitrate round-robin among themselves when requester 0 is idle.
  - Undefined: pure round-robin across all N requesters as described above.

## Test plan
- Single request, N=4, LAT=1: requester 2 with a=3, b=4, c=5 → transfer on edge t; `rsp_valid` after edge t+2 with `rsp_id`=2 and `rsp_data`=17.
- Fairness: all four requesters held valid for 8 transfers → grant order 0,1,2,3,0,1,2,3; every `rsp_id` matches its issue order.
- Wrap-around arithmetic: a=255, b=255, c=0xFFFF → `rsp_data` = (65025+65535) mod 65536 = 65024 (0xFE00).
- `pause` high for 3 cycles while requester 1 is valid → `req_ready` = 0 throughout. The grant occurs on the first edge after `pause` falls; an in-flight result from before the pause is still delivered.
- Asynchronous `rst` pulse asserted mid-cycle with 2 operations in flight → all outputs 0 immediately; no `rsp_valid` after release; the next grant starts from requester 0.
- `FFRA_SCHED_PRIO_EN` defined, requesters 0 and 3 continuously valid → requester 0 is granted every cycle and requester 3 is never granted. Deassert 0 → requester 3 is granted on the next edge.
